// File: rtl/ev_pred_pkg.sv
// Shared decode fields, FSM encoding and 2-bit counter constants for the
// MicroEV20 branch predictor.
package ev_pred_pkg;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam int         CLS_BIT = 13;
  localparam int         TGT_HI  = 10;
  localparam int         TGT_LO  = 0;

  typedef enum logic {IDLE = 1'b0, WAIT_RES = 1'b1} state_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] ctr_upd(input logic [1:0] c, input logic taken);
    if (taken) return (c == CTR_ST)  ? CTR_ST  : c + 2'd1;
    else       return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction
endpackage

// File: rtl/branch_pred_ctrl_if.sv
// Fetch/resolve/redirect bundle between the fetch stage and the predictor.
interface branch_pred_ctrl_if #(
  parameter int PC_W    = 11,
  parameter int INSTR_W = 22
);
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;
  logic               instr_ready;
  logic               pred_taken;
  logic [PC_W-1:0]    next_pc;
  logic               resolve_valid;
  logic               resolve_taken;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;

  modport master (
    output instr_valid, instr, pc, resolve_valid, resolve_taken,
    input  instr_ready, pred_taken, next_pc, redirect_valid, redirect_pc
  );
  modport slave (
    input  instr_valid, instr, pc, resolve_valid, resolve_taken,
    output instr_ready, pred_taken, next_pc, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/branch_pred_ctrl_bp_ctr_table.sv
// 2^IDX_W entries of 2-bit saturating counters: async read, sync update,
// reset to weakly not-taken.
module bp_ctr_table
  import ev_pred_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  localparam int N = 1 << IDX_W;

  logic [N-1:0][1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) ctr_d[wr_idx] = ctr_upd(ctr_q[wr_idx], wr_taken);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ctr_q <= {N{CTR_WNT}};
    else        ctr_q <= ctr_d;

  assign rd_ctr = ctr_q[rd_idx];
endmodule

// File: rtl/branch_pred_ctrl.sv
// Fetch-stage branch predictor: one conditional jump in flight, redirect on
// mispredict. Define PRED_STATS_EN to build the branch/mispredict counters.
module branch_pred_ctrl
  import ev_pred_pkg::*;
#(
  parameter int IDX_W   = 4,
  parameter int PC_W    = 11,
  parameter int INSTR_W = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_pred_ctrl_if.slave   bp,
  output logic [15:0]         branch_cnt,
  output logic [15:0]         mispred_cnt
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PC_W-1:0]  tgt_q, tgt_d, ft_q, ft_d;
  logic             pred_q, pred_d;
  logic             redir_v_q, redir_v_d;
  logic [PC_W-1:0]  redir_pc_q, redir_pc_d;

  logic [2:0]      op;
  logic            is_jmp, is_cond, accept, resolve, mispred;
  logic [1:0]      rd_ctr;
  logic [PC_W-1:0] tgt;
  logic            unused_instr_hi;

  assign op      = bp.instr[CLS_BIT -: 3];
  assign is_jmp  = (op == OP_JMP);
  assign is_cond = op[2] && !is_jmp;
  assign tgt     = PC_W'(bp.instr[TGT_HI:TGT_LO]);
  assign unused_instr_hi = ^bp.instr[INSTR_W-1:CLS_BIT+1];

  bp_ctr_table #(.IDX_W(IDX_W)) u_tbl (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (bp.pc[IDX_W-1:0]),
    .rd_ctr   (rd_ctr),
    .wr_en    (resolve),
    .wr_idx   (idx_q),
    .wr_taken (bp.resolve_taken)
  );

  // The redirect cycle carries a wrong-path fetch, so it is not accepted.
  assign bp.instr_ready    = (state_q == IDLE) && !redir_v_q;
  assign bp.pred_taken     = is_cond && rd_ctr[1];
  assign bp.next_pc        = (is_jmp || bp.pred_taken) ? tgt : bp.pc;
  assign bp.redirect_valid = redir_v_q;
  assign bp.redirect_pc    = redir_pc_q;

  assign accept  = bp.instr_valid && bp.instr_ready && is_cond;
  assign resolve = (state_q == WAIT_RES) && bp.resolve_valid;
  assign mispred = resolve && (bp.resolve_taken != pred_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tgt_d      = tgt_q;
    ft_d       = ft_q;
    pred_d     = pred_q;
    redir_v_d  = 1'b0;
    redir_pc_d = redir_pc_q;
    if (resolve) begin
      state_d = IDLE;
      if (mispred) begin
        redir_v_d  = 1'b1;
        redir_pc_d = bp.resolve_taken ? tgt_q : ft_q;
      end
    end else if (accept) begin
      state_d = WAIT_RES;
      idx_d   = bp.pc[IDX_W-1:0];
      tgt_d   = tgt;
      ft_d    = bp.pc;
      pred_d  = bp.pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tgt_q      <= '0;
      ft_q       <= '0;
      pred_q     <= 1'b0;
      redir_v_q  <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tgt_q      <= tgt_d;
      ft_q       <= ft_d;
      pred_q     <= pred_d;
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
    end

`ifdef PRED_STATS_EN
  logic [15:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (resolve && br_cnt_q != 16'hFFFF)  br_cnt_d  = br_cnt_q + 16'd1;
    if (mispred && mis_cnt_q != 16'hFFFF) mis_cnt_d = mis_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end

  assign branch_cnt  = br_cnt_q;
  assign mispred_cnt = mis_cnt_q;
`else
  assign branch_cnt  = '0;
  assign mispred_cnt = '0;
`endif
endmodule
